player: RTL and testbench
=========================

PLAYER -- requirements
Module: player

Interface
REQ-001 clk  in  1  sole system clock; all state changes on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 dclk  in  1  pixel strobe, sampled in clk; a pixel tick is one clk cycle at each detected 0->1 transition.
REQ-004 bulletclk  in  1  motion strobe, sampled in clk; a motion tick is one clk cycle at each detected 0->1 transition.
REQ-005 pause  in  1  freezes motion, firing, collisions and lives when high.
REQ-006 left, right  in  1 each  move-request levels.
REQ-007 a  in  1  fire button; its 0->1 edge, sampled in clk, fires.
REQ-008 game_start_on, game_over_on  in  1 each  title-screen and game-over status.
REQ-009 x, y  in  10 each  current VGA pixel; active area is x 144..783, y 31..510.
REQ-010 e_r_on, e_r_active  in  1 each  red-enemy pixel hit and alive flag.
REQ-011 e_w_on, e_w_active  in  5 each  per-white-enemy pixel hit and alive flags.
REQ-012 p_x, p_y  out  10 each  ship top-left corner.
REQ-013 p_on  out  1  current pixel is inside the ship.
REQ-014 b_on, b_active  out  5 each  per-bullet pixel hit and alive flags.
REQ-015 hit_w_enemy  out  5  per-white-enemy kill pulse.
REQ-016 hit_r_enemy  out  1  red-enemy kill pulse.
REQ-017 p_lives  out  2  lives remaining.
REQ-018 rgb  out  8  pixel colour, RRRGGGBB.

Function
REQ-019 Ship is 32x16 pixels; p_y is constant 470; p_x range is 144..752.
REQ-020 On each motion tick with pause=0, game_start_on=0 and game_over_on=0, the ship moves by 1 pixel.
REQ-021 left=1 with right=0 decrements p_x; right=1 with left=0 increments p_x.
REQ-022 p_x is clamped to 144..752; both left and right high, or neither, gives no move.
REQ-023 Five bullet slots; each bullet is 2 wide x 6 tall.
REQ-024 A fire edge while not paused loads the lowest-index inactive slot with bx=p_x+15, by=p_y-6 and sets b_active.
REQ-025 A fire edge with all five slots active is dropped.
REQ-026 On each motion tick with pause=0, every active bullet does by-=2.
REQ-027 A bullet whose by<33 before the decrement is cleared instead of moving.
REQ-028 p_on=1 when p_x<=x<p_x+32 and p_y<=y<p_y+16, else 0.
REQ-029 b_on[i]=1 when b_active[i]=1 and x,y lie inside bullet i, else 0.
REQ-030 p_on and b_on are combinational from x, y and registered state; both are forced 0 while game_start_on or game_over_on is high.
REQ-031 Kill: on a pixel tick with pause=0, if any b_on bit is set and (e_w_on[k] & e_w_active[k]), hit_w_enemy[k] is 1 for the next clk cycle only, and every bullet with b_on set is cleared.
REQ-032 The red-enemy kill is identical, using e_r_on & e_r_active and hit_r_enemy.
REQ-033 Several enemies may pulse in the same cycle.
REQ-034 Damage: on a pixel tick with pause=0, p_on=1 and any active enemy pixel on, with invulnerability counter 0, p_lives decrements (saturating at 0) and the counter loads 63.
REQ-035 The invulnerability counter decrements on each frame end (pixel tick with x=783, y=510) while not paused.
REQ-036 rgb is 8'hFC when any b_on bit is set, else 8'h1C when p_on=1, else 8'h00; rgb is combinational.
REQ-037 While game_start_on=1: p_x=448, all bullets cleared, p_lives=3, invulnerability counter 0.
REQ-038 While game_over_on=1 (and game_start_on=0): all state is frozen.
REQ-039 Simultaneous fire edge and motion tick: the new bullet spawns without moving that cycle.

Reset
REQ-040 Reset values: p_x=448, p_y=470, b_active=0, bullet positions 0, hit outputs 0, p_lives=3, invulnerability counter 0, strobe edge registers 0.
REQ-041 rst has priority over all other inputs.

Verification
REQ-042 Reset, then left=1 held for 400 motion ticks -> p_x steps 448->144 and stays at 144.
REQ-043 a pulsed six times, ~20 clk apart -> b_active fills 00001..11111; the sixth press is ignored.
REQ-044 Fire, then scan x,y -> b_on=1 only at x=463..464, y=464..469 on the spawn tick; by decreases 2 per motion tick; slot clears after by<33.
REQ-045 Bullet pixel coincident with e_w_on[2]=e_w_active[2]=1 -> one-cycle hit_w_enemy=00100 and that bullet is cleared.
REQ-046 e_r_on=e_r_active=1 over ship pixels for 3 frames -> p_lives drops 3->2 once; pause=1 blocks the loss and all motion.

Source files
------------

// File: rtl/player.sv
// ---------------------------------------------------------------------------
// player -- player ship, bullet pool, kill/damage detection and pixel colour.
//
// Ports
//   clk            system clock, all state changes on its rising edge
//   rst            synchronous active-high reset
//   dclk           pixel strobe; its 0->1 edge (sampled in clk) is a pixel tick
//   bulletclk      motion strobe; its 0->1 edge (sampled in clk) is a motion tick
//   pause          freezes motion, firing, collisions and lives
//   left, right    move-request levels
//   a              fire button, fires on its 0->1 edge
//   game_start_on  title screen: re-initialises ship, bullets and lives
//   game_over_on   game-over screen: freezes all state
//   x, y           current VGA pixel (active area x 144..783, y 31..510)
//   e_r_on/_active red-enemy pixel hit / alive flag
//   e_w_on/_active per-white-enemy pixel hit / alive flags (5)
//   p_x, p_y       ship top-left corner
//   p_on           current pixel lies inside the ship
//   b_on, b_active per-bullet pixel hit / alive flags (5)
//   hit_w_enemy    per-white-enemy one-cycle kill pulse
//   hit_r_enemy    red-enemy one-cycle kill pulse
//   p_lives        lives remaining
//   rgb            pixel colour, RRRGGGBB
// ---------------------------------------------------------------------------
module player (
    input  logic       clk,
    input  logic       rst,
    input  logic       dclk,
    input  logic       bulletclk,
    input  logic       pause,
    input  logic       left,
    input  logic       right,
    input  logic       a,
    input  logic       game_start_on,
    input  logic       game_over_on,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       e_r_on,
    input  logic       e_r_active,
    input  logic [4:0] e_w_on,
    input  logic [4:0] e_w_active,
    output logic [9:0] p_x,
    output logic [9:0] p_y,
    output logic       p_on,
    output logic [4:0] b_on,
    output logic [4:0] b_active,
    output logic [4:0] hit_w_enemy,
    output logic       hit_r_enemy,
    output logic [1:0] p_lives,
    output logic [7:0] rgb
);

    localparam logic [9:0] P_X_HOME   = 10'd448;
    localparam logic [9:0] P_Y_POS    = 10'd470;
    localparam logic [9:0] P_X_MIN    = 10'd144;
    localparam logic [9:0] P_X_MAX    = 10'd752;
    localparam logic [9:0] B_X_OFS    = 10'd15;
    localparam logic [9:0] B_Y_OFS    = 10'd6;
    localparam logic [9:0] B_TOP      = 10'd33;
    localparam logic [9:0] B_STEP     = 10'd2;
    localparam logic [9:0] X_LAST     = 10'd783;
    localparam logic [9:0] Y_LAST     = 10'd510;
    localparam logic [5:0] INV_LOAD   = 6'd63;
    localparam logic [1:0] LIVES_INIT = 2'd3;

    logic       dclk_q, bclk_q, a_q;
    logic [9:0] b_x [5];
    logic [9:0] b_y [5];
    logic [5:0] inv_cnt;

    logic       pix_tick, mot_tick, fire;
    logic       display_on;
    logic [4:0] w_hits;
    logic       r_hit, enemy_pix;
    logic       kill, damage, frame_end;
    logic [4:0] free_slots, fire_sel;

    assign p_y = P_Y_POS;

    assign pix_tick = dclk & ~dclk_q;
    assign mot_tick = bulletclk & ~bclk_q;
    assign fire     = a & ~a_q;

    assign display_on = ~(game_start_on | game_over_on);

    // Comparisons are done at 11 bits so p_x+32 / b_x+2 never wrap.
    assign p_on = display_on
               && ({1'b0, x} >= {1'b0, p_x}) && ({1'b0, x} < ({1'b0, p_x} + 11'd32))
               && ({1'b0, y} >= {1'b0, p_y}) && ({1'b0, y} < ({1'b0, p_y} + 11'd16));

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        b_on = '0;
        for (int i = 0; i < 5; i++) begin
            b_on[i] = display_on && b_active[i]
                   && ({1'b0, x} >= {1'b0, b_x[i]}) && ({1'b0, x} < ({1'b0, b_x[i]} + 11'd2))
                   && ({1'b0, y} >= {1'b0, b_y[i]}) && ({1'b0, y} < ({1'b0, b_y[i]} + 11'd6));
        end
    end

    assign rgb = (|b_on) ? 8'hFC : (p_on ? 8'h1C : 8'h00);

    assign w_hits    = e_w_on & e_w_active;
    assign r_hit     = e_r_on & e_r_active;
    assign enemy_pix = r_hit | (|w_hits);

    assign kill      = pix_tick & ~pause & (|b_on) & enemy_pix;
    assign damage    = pix_tick & ~pause & p_on & enemy_pix & (inv_cnt == 6'd0);
    assign frame_end = pix_tick & ~pause & (x == X_LAST) & (y == Y_LAST);

    // Lowest inactive slot as a one-hot mask (isolate lowest set bit).
    assign free_slots = ~b_active;
    assign fire_sel   = free_slots & (~free_slots + 5'd1);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            dclk_q      <= 1'b0;
            bclk_q      <= 1'b0;
            a_q         <= 1'b0;
            p_x         <= P_X_HOME;
            b_active    <= '0;
            hit_w_enemy <= '0;
            hit_r_enemy <= 1'b0;
            p_lives     <= LIVES_INIT;
            inv_cnt     <= '0;
            // NOTE: the bullet position arrays are small register files with
            // defined reset values, so they are reset explicitly here.
            for (int i = 0; i < 5; i++) begin
                b_x[i] <= '0;
                b_y[i] <= '0;
            end
        end else begin
            dclk_q      <= dclk;
            bclk_q      <= bulletclk;
            a_q         <= a;
            hit_w_enemy <= '0;
            hit_r_enemy <= 1'b0;

            if (game_start_on) begin
                p_x      <= P_X_HOME;
                b_active <= '0;
                p_lives  <= LIVES_INIT;
                inv_cnt  <= '0;
                for (int i = 0; i < 5; i++) begin
                    b_x[i] <= '0;
                    b_y[i] <= '0;
                end
            end else if (!game_over_on && !pause) begin
                if (mot_tick) begin
                    if (left && !right && (p_x > P_X_MIN))
                        p_x <= p_x - 10'd1;
                    else if (right && !left && (p_x < P_X_MAX))
                        p_x <= p_x + 10'd1;
                end

                if (kill) begin
                    hit_w_enemy <= w_hits;
                    hit_r_enemy <= r_hit;
                end

                // A freshly loaded slot was inactive, so it never also moves
                // on a coincident motion tick.
                for (int i = 0; i < 5; i++) begin
                    if (kill && b_on[i]) begin
                        b_active[i] <= 1'b0;
                    end else if (fire && fire_sel[i]) begin
                        b_active[i] <= 1'b1;
                        b_x[i]      <= p_x + B_X_OFS;
                        b_y[i]      <= P_Y_POS - B_Y_OFS;
                    end else if (mot_tick && b_active[i]) begin
                        if (b_y[i] < B_TOP)
                            b_active[i] <= 1'b0;
                        else
                            b_y[i] <= b_y[i] - B_STEP;
                    end
                end

                // damage needs inv_cnt==0 and the decrement needs inv_cnt!=0,
                // so the two never collide.
                if (damage) begin
                    if (p_lives != 2'd0)
                        p_lives <= p_lives - 2'd1;
                    inv_cnt <= INV_LOAD;
                end else if (frame_end && (inv_cnt != 6'd0)) begin
                    inv_cnt <= inv_cnt - 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_player.sv
// ---------------------------------------------------------------------------
// tb_player -- self-checking bench for player.
// Combinational pixel checks come from a vector table; expected values are
// queued when stimulus is driven and compared when the DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_player;

    logic       clk = 1'b0;
    logic       rst, dclk, bulletclk, pause, left, right, a;
    logic       game_start_on, game_over_on;
    logic [9:0] x, y;
    logic       e_r_on, e_r_active;
    logic [4:0] e_w_on, e_w_active;
    logic [9:0] p_x, p_y;
    logic       p_on;
    logic [4:0] b_on, b_active, hit_w_enemy;
    logic       hit_r_enemy;
    logic [1:0] p_lives;
    logic [7:0] rgb;

    player dut (
        .clk(clk), .rst(rst), .dclk(dclk), .bulletclk(bulletclk), .pause(pause),
        .left(left), .right(right), .a(a),
        .game_start_on(game_start_on), .game_over_on(game_over_on),
        .x(x), .y(y), .e_r_on(e_r_on), .e_r_active(e_r_active),
        .e_w_on(e_w_on), .e_w_active(e_w_active),
        .p_x(p_x), .p_y(p_y), .p_on(p_on), .b_on(b_on), .b_active(b_active),
        .hit_w_enemy(hit_w_enemy), .hit_r_enemy(hit_r_enemy),
        .p_lives(p_lives), .rgb(rgb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic       go;
        logic [9:0] vx;
        logic [9:0] vy;
        logic       ep;
        logic [4:0] eb;
        logic [7:0] ergb;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_val(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic compare_next(input logic [31:0] got);
        sb_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got %0h, expected nothing pending", got);
        end else begin
            e = sb.pop_front();
            check(e.name, got, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic motion_tick();
        bulletclk = 1'b1;
        step();
        bulletclk = 1'b0;
        step();
    endtask

    task automatic pixel_tick(input logic [9:0] px, input logic [9:0] py);
        x    = px;
        y    = py;
        dclk = 1'b1;
        step();
        dclk = 1'b0;
        step();
    endtask

    task automatic fire_press();
        a = 1'b1;
        step();
        a = 1'b0;
        step();
    endtask

    task automatic start_pulse();
        game_start_on = 1'b1;
        step();
        game_start_on = 1'b0;
        step();
    endtask

    task automatic pix_check(input string name, input logic [9:0] px, input logic [9:0] py,
                             input logic [4:0] exp_b);
        x = px;
        y = py;
        expect_val(name, {27'd0, exp_b});
        #1;
        compare_next({27'd0, b_on});
    endtask

    initial begin
        int k;
        logic [4:0] fill_exp [6];

        // {game_over_on, x, y, p_on, b_on, rgb} with the ship at 448,470 and
        // one bullet freshly spawned at 463,464.
        vecs[0]  = '{1'b0, 10'd463, 10'd464, 1'b0, 5'b00001, 8'hFC};
        vecs[1]  = '{1'b0, 10'd464, 10'd469, 1'b0, 5'b00001, 8'hFC};
        vecs[2]  = '{1'b0, 10'd462, 10'd464, 1'b0, 5'b00000, 8'h00};
        vecs[3]  = '{1'b0, 10'd465, 10'd469, 1'b0, 5'b00000, 8'h00};
        vecs[4]  = '{1'b0, 10'd463, 10'd463, 1'b0, 5'b00000, 8'h00};
        vecs[5]  = '{1'b0, 10'd463, 10'd470, 1'b1, 5'b00000, 8'h1C};
        vecs[6]  = '{1'b0, 10'd448, 10'd470, 1'b1, 5'b00000, 8'h1C};
        vecs[7]  = '{1'b0, 10'd447, 10'd470, 1'b0, 5'b00000, 8'h00};
        vecs[8]  = '{1'b0, 10'd479, 10'd485, 1'b1, 5'b00000, 8'h1C};
        vecs[9]  = '{1'b0, 10'd480, 10'd485, 1'b0, 5'b00000, 8'h00};
        vecs[10] = '{1'b0, 10'd479, 10'd486, 1'b0, 5'b00000, 8'h00};
        vecs[11] = '{1'b1, 10'd463, 10'd464, 1'b0, 5'b00000, 8'h00};

        fill_exp = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b11111};

        rst = 1'b1; dclk = 1'b0; bulletclk = 1'b0; pause = 1'b0;
        left = 1'b0; right = 1'b0; a = 1'b0;
        game_start_on = 1'b0; game_over_on = 1'b0;
        x = 10'd0; y = 10'd0;
        e_r_on = 1'b0; e_r_active = 1'b0; e_w_on = '0; e_w_active = '0;

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_p_x", p_x, 448);
        check("rst_p_y", p_y, 470);
        check("rst_b_active", b_active, 0);
        check("rst_p_lives", p_lives, 3);
        check("rst_hit_w", hit_w_enemy, 0);
        check("rst_hit_r", hit_r_enemy, 0);

        // Spawn geometry and pixel colour table
        fire_press();
        check("spawn_b_active", b_active, 5'b00001);
        for (int i = 0; i < 12; i++) begin
            game_over_on = vecs[i].go;
            x = vecs[i].vx;
            y = vecs[i].vy;
            expect_val($sformatf("vec%0d_p_on", i), {31'd0, vecs[i].ep});
            expect_val($sformatf("vec%0d_b_on", i), {27'd0, vecs[i].eb});
            expect_val($sformatf("vec%0d_rgb", i), {24'd0, vecs[i].ergb});
            #1;
            compare_next({31'd0, p_on});
            compare_next({27'd0, b_on});
            compare_next({24'd0, rgb});
        end
        game_over_on = 1'b0;

        // Bullet climbs 2 per motion tick and clears once by<33
        motion_tick();
        pix_check("move_top", 10'd463, 10'd462, 5'b00001);
        pix_check("move_bottom", 10'd463, 10'd468, 5'b00000);
        k = 1;
        while (b_active[0] && k < 300) begin
            motion_tick();
            k++;
        end
        check("bullet_life_ticks", k, 217);
        check("ship_still", p_x, 448);

        // Six presses fill five slots, the sixth is dropped
        for (int i = 0; i < 6; i++) begin
            expect_val($sformatf("fill%0d", i), {27'd0, fill_exp[i]});
            fire_press();
            repeat (18) step();
            compare_next({27'd0, b_active});
        end

        start_pulse();
        check("start_b_active", b_active, 0);
        check("start_p_lives", p_lives, 3);

        // Single white-enemy kill
        fire_press();
        e_w_on = 5'b00100; e_w_active = 5'b00100;
        x = 10'd463; y = 10'd464;
        dclk = 1'b1;
        step();
        check("kill_hit_w", hit_w_enemy, 5'b00100);
        check("kill_hit_r", hit_r_enemy, 0);
        check("kill_b_cleared", b_active, 0);
        dclk = 1'b0;
        step();
        check("kill_pulse_end", hit_w_enemy, 0);

        // Slot 0 moved out of the way, slot 1 on the probe pixel
        fire_press();
        repeat (4) motion_tick();
        fire_press();
        check("two_bullets", b_active, 5'b00011);

        // Enemy pixel on but not alive: no kill
        e_w_on = 5'b00010; e_w_active = 5'b00000;
        pixel_tick(10'd463, 10'd464);
        check("dead_enemy_b_active", b_active, 5'b00011);

        // Paused: no kill
        pause = 1'b1;
        e_w_on = 5'b00100; e_w_active = 5'b00100;
        pixel_tick(10'd463, 10'd464);
        check("pause_no_kill", b_active, 5'b00011);
        pause = 1'b0;

        // Multiple enemies at once, only the bullet under the pixel clears
        e_w_on = 5'b10001; e_w_active = 5'b10001;
        e_r_on = 1'b1; e_r_active = 1'b1;
        dclk = 1'b1;
        step();
        check("multi_hit_w", hit_w_enemy, 5'b10001);
        check("multi_hit_r", hit_r_enemy, 1);
        check("multi_b_active", b_active, 5'b00001);
        dclk = 1'b0;
        step();
        e_w_on = '0; e_w_active = '0;

        // Damage over three frames costs one life
        start_pulse();
        for (int f = 0; f < 3; f++) begin
            pixel_tick(10'd460, 10'd475);
            check($sformatf("frame%0d_lives", f), p_lives, 2);
            pixel_tick(10'd783, 10'd510);
        end
        repeat (59) pixel_tick(10'd783, 10'd510);
        pixel_tick(10'd460, 10'd475);
        check("inv_still_one", p_lives, 2);
        pixel_tick(10'd783, 10'd510);
        pixel_tick(10'd460, 10'd475);
        check("inv_expired", p_lives, 1);
        repeat (63) pixel_tick(10'd783, 10'd510);
        pixel_tick(10'd460, 10'd475);
        check("lives_zero", p_lives, 0);
        repeat (63) pixel_tick(10'd783, 10'd510);
        pixel_tick(10'd460, 10'd475);
        check("lives_saturate", p_lives, 0);

        // Pause blocks damage, motion and firing
        start_pulse();
        pause = 1'b1;
        left  = 1'b1;
        pixel_tick(10'd460, 10'd475);
        motion_tick();
        fire_press();
        check("pause_lives", p_lives, 3);
        check("pause_p_x", p_x, 448);
        check("pause_b_active", b_active, 0);
        pause = 1'b0;
        e_r_on = 1'b0; e_r_active = 1'b0;

        // Ship motion and clamping
        motion_tick();
        check("left_one", p_x, 447);
        repeat (303) motion_tick();
        check("left_min", p_x, 144);
        repeat (96) motion_tick();
        check("left_clamp", p_x, 144);
        right = 1'b1;
        motion_tick();
        check("both_no_move", p_x, 144);
        left = 1'b0;
        motion_tick();
        check("right_one", p_x, 145);
        repeat (700) motion_tick();
        check("right_clamp", p_x, 752);
        right = 1'b0;

        // Game over freezes ship and bullets
        start_pulse();
        fire_press();
        game_over_on = 1'b1;
        left = 1'b1;
        motion_tick();
        check("over_p_x", p_x, 448);
        check("over_b_active", b_active, 5'b00001);
        game_over_on = 1'b0;
        left = 1'b0;
        pix_check("over_b_unmoved", 10'd463, 10'd469, 5'b00001);

        // Fire and motion tick together: new bullet does not move
        start_pulse();
        a = 1'b1; bulletclk = 1'b1;
        step();
        a = 1'b0; bulletclk = 1'b0;
        step();
        pix_check("fire_motion_bottom", 10'd463, 10'd469, 5'b00001);
        pix_check("fire_motion_above", 10'd463, 10'd463, 5'b00000);

        // Reset overrides active inputs
        rst = 1'b1; a = 1'b1; bulletclk = 1'b1; left = 1'b1;
        step();
        step();
        check("rst_prio_p_x", p_x, 448);
        check("rst_prio_b_active", b_active, 0);
        check("rst_prio_lives", p_lives, 3);
        rst = 1'b0; a = 1'b0; bulletclk = 1'b0; left = 1'b0;

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
